// File: rtl/dc_offset_cal_seq_if.sv
// Sample/control bundle for the DC-offset calibration sequencer.
// The master drives the controls and the I/Q stream. The slave (the sequencer)
// returns the corrected stream, the latched offsets and the status flags.
interface dc_offset_cal_seq_if;
  logic               start;
  logic               abort;
  logic               continuous;
  logic               in_valid;
  logic signed [15:0] data_in_i;
  logic signed [15:0] data_in_q;
  logic               out_valid;
  logic signed [15:0] data_out_i;
  logic signed [15:0] data_out_q;
  logic signed [15:0] dc_i;
  logic signed [15:0] dc_q;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, continuous, in_valid, data_in_i, data_in_q,
    input  out_valid, data_out_i, data_out_q, dc_i, dc_q, busy, done
  );

  modport slave (
    input  start, abort, continuous, in_valid, data_in_i, data_in_q,
    output out_valid, data_out_i, data_out_q, dc_i, dc_q, busy, done
  );
endinterface

// File: rtl/dc_offset_cal_seq.sv
// DC-offset calibration sequencer for an I/Q pair.
// It first discards SETTLE valid samples. It then averages 2^LOG2_N samples of I,
// followed by 2^LOG2_N samples of Q, in one shared accumulator. Both means are
// latched as offsets in the same edge. Those offsets are subtracted, with
// saturation, from the sample stream.
module dc_offset_cal_seq #(
  parameter int LOG2_N = 10,
  parameter int SETTLE = 64
) (
  input logic              clk,
  input logic              reset_n,
  dc_offset_cal_seq_if.slave bus
);

  localparam int ACC_W = 16 + LOG2_N;
  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int CNT_W = (LOG2_N + 1 > SET_W) ? LOG2_N + 1 : SET_W;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << LOG2_N) - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ACC_I,
    S_ACC_Q,
    S_UPDATE
  } state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [15:0]       mean_i_q;
  logic signed [15:0]       mean_q_q;
  logic signed [15:0]       off_i_q;
  logic signed [15:0]       off_q_q;
  logic                     done_q;
  logic                     out_valid_q;
  logic signed [15:0]       out_i_q;
  logic signed [15:0]       out_q_q;

  // The shared accumulator adds whichever channel the current phase is averaging.
  logic signed [15:0]      sample_d;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [15:0]      mean_d;

  assign sample_d = (state_q == S_ACC_Q) ? bus.data_in_q : bus.data_in_i;
  assign acc_d    = acc_q + {{LOG2_N{sample_d[15]}}, sample_d};
  // The arithmetic shift rounds toward -inf. The mean of 16-bit samples always fits 16 bits.
  assign mean_d   = 16'(acc_d >>> LOG2_N);

  // The 17-bit differences cannot overflow. Saturation clamps them back to 16 bits.
  logic [16:0] diff_i_d;
  logic [16:0] diff_q_d;

  assign diff_i_d = {bus.data_in_i[15], bus.data_in_i} - {off_i_q[15], off_i_q};
  assign diff_q_d = {bus.data_in_q[15], bus.data_in_q} - {off_q_q[15], off_q_q};

  function automatic logic signed [15:0] sat16(input logic [16:0] d);
    if (d[16] != d[15]) return d[16] ? 16'sh8000 : 16'sh7fff;
    return d[15:0];
  endfunction

  // Calibration FSM: sequences the phases, counts valid samples and latches the offsets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mean_i_q <= '0;
      mean_q_q <= '0;
      off_i_q  <= '0;
      off_q_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments for state so that every register here
      // sees the values from before the edge, whatever order the statements are in.
      done_q <= 1'b0;
      if (bus.abort) begin
        // Abort overrides start and every transition. The offsets are kept.
        state_q <= S_IDLE;
        cnt_q   <= '0;
        acc_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              state_q <= (SETTLE > 0) ? S_SETTLE : S_ACC_I;
              cnt_q   <= '0;
              acc_q   <= '0;
            end
          end
          S_SETTLE: begin
            if (bus.in_valid) begin
              if (cnt_q == SET_LAST) begin
                cnt_q   <= '0;
                state_q <= S_ACC_I;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          S_ACC_I, S_ACC_Q: begin
            if (bus.in_valid) begin
              if (cnt_q == WIN_LAST) begin
                cnt_q <= '0;
                acc_q <= '0;
                if (state_q == S_ACC_I) begin
                  mean_i_q <= mean_d;
                  state_q  <= S_ACC_Q;
                end else begin
                  mean_q_q <= mean_d;
                  state_q  <= S_UPDATE;
                end
              end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          S_UPDATE: begin
            off_i_q <= mean_i_q;
            off_q_q <= mean_q_q;
            done_q  <= 1'b1;
            state_q <= bus.continuous ? S_ACC_I : S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Correction path: a registered saturating subtraction that holds when no sample arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_i_q <= sat16(diff_i_d);
        out_q_q <= sat16(diff_q_d);
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.data_out_i = out_i_q;
  assign bus.data_out_q = out_q_q;
  assign bus.dc_i       = off_i_q;
  assign bus.dc_q       = off_q_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;

endmodule
